// File: rtl/rv_pkg.sv
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared RV32I encoder constants: format codes, opcodes, NOP word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    // Format codes line up with the decoder's ImmSrc values for I/S/B/J/U
    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } pack_res_t;

endpackage

`default_nettype wire

// File: rtl/rv_instr_encoder_if.sv
// ============================================================================
// Module   : rv_instr_encoder_if
// Purpose  : Request/response valid-ready bundle of the instruction encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv_instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_op;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_op, in_funct3, in_funct7b5,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_op, in_funct3, in_funct7b5,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

`default_nettype wire

// File: rtl/rv_instr_pack.sv
// ============================================================================
// Module   : rv_instr_pack
// Purpose  : Combinational RV32I field placement and legality check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_instr_pack
    import rv_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output pack_res_t   res_o
);

    logic signed [31:0] simm;
    logic               is_shift;
    logic               illegal;
    logic [31:0]        instr;

    assign simm     = $signed(imm_i);
    // funct3 001 (slli) and 101 (srli/srai) share the shamt layout
    assign is_shift = (fmt_i == FMT_I) && (op_i == OP_OPIMM) && (funct3_i[1:0] == 2'b01);

    always_comb begin
        illegal = (op_i[1:0] != 2'b11);
        case (fmt_i)
            FMT_I: if (simm < -32'sd2048 || simm > 32'sd2047 ||
                       (is_shift && (simm < 32'sd0 || simm > 32'sd31)))
                       illegal = 1'b1;
            FMT_S: if (simm < -32'sd2048 || simm > 32'sd2047)
                       illegal = 1'b1;
            FMT_B: if (simm < -32'sd4096 || simm > 32'sd4094 || imm_i[0])
                       illegal = 1'b1;
            FMT_J: if (simm < -32'sd1048576 || simm > 32'sd1048574 || imm_i[0])
                       illegal = 1'b1;
            FMT_U: if (imm_i[11:0] != 12'h000)
                       illegal = 1'b1;
            FMT_R: ;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        instr = 32'h0;
        case (fmt_i)
            FMT_R: instr = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            FMT_I: instr = is_shift
                         ? {1'b0, funct7b5_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, op_i}
                         : {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
            FMT_S: instr = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
            FMT_B: instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i};
            FMT_U: instr = {imm_i[31:12], rd_i, op_i};
            FMT_J: instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
            default: instr = 32'h0;
        endcase
    end

    assign res_o.instr = illegal ? NOP : instr;
    assign res_o.err   = illegal;

endmodule

`default_nettype wire

// File: rtl/rv_instr_encoder.sv
// ============================================================================
// Module   : rv_instr_encoder
// Purpose  : Registered valid/ready wrapper around rv_instr_pack with counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    rv_instr_encoder_if.slave    bus,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 err_sticky
);

    pack_res_t          pack_res;
    logic               accept;
    logic               valid_q,  valid_d;
    logic [31:0]        instr_q,  instr_d;
    logic               err_q,    err_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               sticky_q, sticky_d;

    rv_instr_pack u_pack (
        .fmt_i      (bus.in_fmt),
        .op_i       (bus.in_op),
        .funct3_i   (bus.in_funct3),
        .funct7b5_i (bus.in_funct7b5),
        .rd_i       (bus.in_rd),
        .rs1_i      (bus.in_rs1),
        .rs2_i      (bus.in_rs2),
        .imm_i      (bus.in_imm),
        .res_o      (pack_res)
    );

    // The single output slot frees up in the same cycle it is popped
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d  = valid_q;
        instr_d  = instr_q;
        err_d    = err_q;
        count_d  = count_q;
        sticky_d = sticky_q;
        if (accept) begin
            valid_d = 1'b1;
            instr_d = pack_res.instr;
            err_d   = pack_res.err;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
        if (clr) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (accept) begin
            count_d  = count_q + CNT_W'(1);
            sticky_d = sticky_q | pack_res.err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            err_q    <= 1'b0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_err   = err_q;
    assign instr_count   = count_q;
    assign err_sticky    = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
// ============================================================================
// Module   : tb_rv_instr_encoder
// Purpose  : Self-checking bench for rv_instr_encoder (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [15:0] instr_count;
    logic        err_sticky;
    int          n_pass = 0;
    int          n_total = 0;

    int bnd [0:17] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                       -1048577, -1048576, 1048574, 1048576, 31, 32, -1,
                       305418240, -4096};

    rv_instr_encoder_if bus ();

    rv_instr_encoder #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .bus         (bus),
        .instr_count (instr_count),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoding built from the bit-field rules with plain arithmetic
    function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
            input logic [2:0] f3, input logic f7, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] o, d, t, r1, r2, s7, w;
        int  s;
        logic bad, sh;
        o = 32'(op); d = 32'(rd); t = 32'(f3); r1 = 32'(rs1); r2 = 32'(rs2); s7 = 32'(f7);
        s   = $signed(imm);
        sh  = (fmt == 3'd0) && (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        bad = (o % 32'd4 != 32'd3) || (fmt > 3'd5);
        case (fmt)
            3'd0: bad = bad || s < -2048 || s > 2047 || (sh && (s < 0 || s > 31));
            3'd1: bad = bad || s < -2048 || s > 2047;
            3'd2: bad = bad || s < -4096 || s > 4094 || (s % 2) != 0;
            3'd3: bad = bad || s < -1048576 || s > 1048574 || (s % 2) != 0;
            3'd4: bad = bad || (imm % 32'd4096) != 32'd0;
            default: ;
        endcase
        w = o + t * 32'd4096 + r1 * 32'h8000;
        case (fmt)
            3'd0: w = w + d * 32'd128 + (sh ? (imm % 32'd32) * 32'h100000 + s7 * 32'h40000000
                                            : (imm % 32'd4096) * 32'h100000);
            3'd1: w = w + (imm % 32'd32) * 32'd128 + ((imm / 32'd32) % 32'd128) * 32'h2000000
                        + r2 * 32'h100000;
            3'd2: w = w + ((imm / 32'd2) % 32'd16) * 32'd256 + ((imm / 32'd2048) % 32'd2) * 32'd128
                        + ((imm / 32'd32) % 32'd64) * 32'h2000000
                        + ((imm / 32'd4096) % 32'd2) * 32'h80000000 + r2 * 32'h100000;
            3'd3: w = o + d * 32'd128 + ((imm / 32'd4096) % 32'd256) * 32'd4096
                        + ((imm / 32'd2048) % 32'd2) * 32'h100000
                        + ((imm / 32'd2) % 32'd1024) * 32'h200000
                        + ((imm / 32'h100000) % 32'd2) * 32'h80000000;
            3'd4: w = o + d * 32'd128 + (imm / 32'd4096) * 32'd4096;
            default: w = w + d * 32'd128 + r2 * 32'h100000 + s7 * 32'h40000000;
        endcase
        return {bad ? 32'h13 : w, bad};
    endfunction

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
            input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [31:0] imm);
        bus.in_valid = 1'b1; bus.in_fmt = fmt; bus.in_op = op; bus.in_funct3 = f3;
        bus.in_funct7b5 = f7; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_imm = imm;
    endtask

    task automatic pulse_clr();
        @(negedge clk); bus.in_valid = 1'b0; clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_instr !== 32'h0) $display("FAIL reset_out_instr got %h want 0", bus.out_instr); else n_pass++;
        n_total++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", bus.out_err); else n_pass++;
        n_total++; if (instr_count !== 16'd0) $display("FAIL reset_count got %0d want 0", instr_count); else n_pass++;
        n_total++; if (err_sticky !== 1'b0) $display("FAIL reset_sticky got %b want 0", err_sticky); else n_pass++;
    endtask

    typedef struct packed {
        logic [2:0] fmt; logic [6:0] op; logic [2:0] f3; logic f7;
        logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2; logic [31:0] imm; logic [31:0] exp;
    } vec_t;

    task automatic test_encodings();
        vec_t v [0:6];
        v[0] = '{3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093};
        v[1] = '{3'd1, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423};
        v[2] = '{3'd2, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3};
        v[3] = '{3'd3, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF};
        v[4] = '{3'd4, 7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7};
        v[5] = '{3'd0, 7'h13, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,          32'h4030D093};
        v[6] = '{3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,   32'h80000093};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            set_req(v[i].fmt, v[i].op, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            @(posedge clk); #1;
            n_total++; if (bus.out_valid !== 1'b1) $display("FAIL enc%0d_valid got %b want 1", i, bus.out_valid); else n_pass++;
            n_total++; if (bus.out_instr !== v[i].exp) $display("FAIL enc%0d_instr got %h want %h", i, bus.out_instr, v[i].exp); else n_pass++;
            n_total++; if (bus.out_err !== 1'b0) $display("FAIL enc%0d_err got %b want 0", i, bus.out_err); else n_pass++;
        end
        @(negedge clk); bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse_clr();
        bus.out_ready = 1'b1;
        set_req(3'd5, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(posedge clk); #1;
        n_total++; if (bus.out_instr !== 32'h002081B3) $display("FAIL b2b_add got %h want 002081b3", bus.out_instr); else n_pass++;
        @(negedge clk);
        set_req(3'd5, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_instr !== 32'h402081B3) $display("FAIL b2b_sub got %h want 402081b3", bus.out_instr); else n_pass++;
        n_total++; if (instr_count !== 16'd2) $display("FAIL b2b_count got %0d want 2", instr_count); else n_pass++;
        @(negedge clk); bus.in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        vec_t v [0:2];
        v[0] = '{3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h13};
        v[1] = '{3'd2, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,    32'h13};
        v[2] = '{3'd7, 7'h33, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0,    32'h13};
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            set_req(v[i].fmt, v[i].op, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            @(posedge clk); #1;
            n_total++; if (bus.out_instr !== v[i].exp) $display("FAIL ill%0d_instr got %h want 00000013", i, bus.out_instr); else n_pass++;
            n_total++; if (bus.out_err !== 1'b1) $display("FAIL ill%0d_err got %b want 1", i, bus.out_err); else n_pass++;
            n_total++; if (err_sticky !== 1'b1) $display("FAIL ill%0d_sticky got %b want 1", i, err_sticky); else n_pass++;
        end
        @(negedge clk); bus.in_valid = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        n_total++; if (instr_count !== 16'd0) $display("FAIL clr_count got %0d want 0", instr_count); else n_pass++;
        n_total++; if (err_sticky !== 1'b0) $display("FAIL clr_sticky got %b want 0", err_sticky); else n_pass++;
        // clr beats a same-cycle illegal accept but leaves the output stage alone
        @(negedge clk);
        set_req(3'd7, 7'h33, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0);
        @(posedge clk); #1;
        n_total++; if (instr_count !== 16'd0) $display("FAIL clrprio_count got %0d want 0", instr_count); else n_pass++;
        n_total++; if (err_sticky !== 1'b0) $display("FAIL clrprio_sticky got %b want 0", err_sticky); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1) $display("FAIL clrprio_out got v=%b e=%b want v=1 e=1", bus.out_valid, bus.out_err); else n_pass++;
        @(negedge clk); bus.in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [32:0] ea, eb;
        ea = ref_encode(3'd0, 7'h13, 3'd0, 1'b0, 5'd4, 5'd4, 5'd0, 32'd17);
        eb = ref_encode(3'd0, 7'h13, 3'd7, 1'b0, 5'd6, 5'd5, 5'd0, 32'hFFFFFFFF);
        pulse_clr();
        bus.out_ready = 1'b0;
        set_req(3'd0, 7'h13, 3'd0, 1'b0, 5'd4, 5'd4, 5'd0, 32'd17);
        @(posedge clk); #1;
        n_total++; if (bus.out_instr !== ea[32:1]) $display("FAIL bp_first got %h want %h", bus.out_instr, ea[32:1]); else n_pass++;
        @(negedge clk);
        set_req(3'd0, 7'h13, 3'd7, 1'b0, 5'd6, 5'd5, 5'd0, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got %b want 0", i, bus.in_ready); else n_pass++;
            n_total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== ea[32:1]) $display("FAIL bp%0d_hold got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_instr, ea[32:1]); else n_pass++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== eb[32:1]) $display("FAIL bp_second got v=%b %h want v=1 %h", bus.out_valid, bus.out_instr, eb[32:1]); else n_pass++;
        n_total++; if (instr_count !== 16'd2) $display("FAIL bp_count got %0d want 2", instr_count); else n_pass++;
        @(negedge clk); bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", bus.out_valid); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [32:0] q[$];
        logic [15:0] m_count;
        logic        m_sticky, acc, pop;
        logic [2:0]  fmt; logic [6:0] op; logic [31:0] imm; int k;
        pulse_clr();
        m_count = 16'd0; m_sticky = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_total++; if (bus.out_valid !== (q.size() != 0)) $display("FAIL rnd%0d_valid got %b want %b", cyc, bus.out_valid, q.size() != 0); else n_pass++;
            if (q.size() != 0) begin
                n_total++; if ({bus.out_instr, bus.out_err} !== q[0]) $display("FAIL rnd%0d_out got %h/%b want %h/%b", cyc, bus.out_instr, bus.out_err, q[0][32:1], q[0][0]); else n_pass++;
            end
            n_total++; if (instr_count !== m_count || err_sticky !== m_sticky) $display("FAIL rnd%0d_cnt got %0d/%b want %0d/%b", cyc, instr_count, err_sticky, m_count, m_sticky); else n_pass++;
            fmt = 3'($urandom_range(0, 7));
            case (fmt)
                3'd0: op = ($urandom_range(0, 2) != 0) ? 7'h13 : 7'h03;
                3'd1: op = 7'h23;
                3'd2: op = 7'h63;
                3'd3: op = 7'h6F;
                3'd4: op = 7'h37;
                default: op = 7'h33;
            endcase
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            k = int'($urandom_range(0, 9));
            if (k < 4) imm = 32'(int'($urandom_range(0, 80)) - 40);
            else if (k == 4) imm = $urandom;
            else imm = 32'(bnd[$urandom_range(0, 17)]);
            if (fmt == 3'd4 && $urandom_range(0, 1) == 1) imm[11:0] = 12'h000;
            set_req(fmt, op, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            clr           = ($urandom_range(0, 39) == 0);
            #1;
            n_total++; if (bus.in_ready !== (q.size() == 0 || bus.out_ready)) $display("FAIL rnd%0d_in_ready got %b", cyc, bus.in_ready); else n_pass++;
            acc = bus.in_valid && (q.size() == 0 || bus.out_ready);
            pop = (q.size() != 0) && bus.out_ready;
            @(posedge clk);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_encode(bus.in_fmt, bus.in_op, bus.in_funct3, bus.in_funct7b5,
                                            bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm));
            if (clr) begin
                m_count = 16'd0; m_sticky = 1'b0;
            end else if (acc) begin
                m_count = m_count + 16'd1;
                m_sticky = m_sticky | q[q.size() - 1][0];
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; clr = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_req(3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(posedge clk); #1;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", bus.out_valid); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_async_valid got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (instr_count !== 16'd0) $display("FAIL rst_async_count got %0d want 0", instr_count); else n_pass++;
        @(negedge clk); bus.in_valid = 1'b0; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_stale%0d got %b want 0", i, bus.out_valid); else n_pass++;
        end
        bus.out_ready = 1'b1;
        set_req(3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(posedge clk); #1;
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00500093) $display("FAIL rst_after got v=%b %h want v=1 00500093", bus.out_valid, bus.out_instr); else n_pass++;
        @(negedge clk); bus.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        set_req(3'd0, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_encodings();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_random();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
